// File: rtl/lc3_decode_rf.sv
// lc3_decode_rf: LC3 decode/operand-fetch stage with 8x16 register file and n/z/p register. Rev 1.0
// Optional build macro LC3_WB_BYPASS_EN: same-cycle writeback data bypasses into captured operands.
`default_nettype none

module lc3_decode_rf #(
  parameter int         NREGS    = 8,
  parameter logic [2:0] RESET_CC = 3'b010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_opcode,
  output logic [15:0]              out_regA,
  output logic [15:0]              out_regB,
  output logic [$clog2(NREGS)-1:0] out_dr,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [15:0]              wb_data,
  input  logic                     wb_setcc,
  output logic                     cc_n,
  output logic                     cc_z,
  output logic                     cc_p
);

  localparam int IDX_W = $clog2(NREGS);

  logic [15:0]      regs [NREGS];
  logic [2:0]       cc;
  logic [2:0]       cc_next;
  logic             accept;
  logic [IDX_W-1:0] sra;
  logic [IDX_W-1:0] srb;
  logic [15:0]      rd_a;
  logic [15:0]      rd_b;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sra      = in_instr[11:9];
  assign srb      = in_instr[IDX_W-1:0];

  always_comb begin
    rd_a = regs[sra];
    rd_b = regs[srb];
`ifdef LC3_WB_BYPASS_EN
    if (wb_en && (wb_addr == sra)) rd_a = wb_data;
    if (wb_en && (wb_addr == srb)) rd_b = wb_data;
`endif
  end

  always_comb begin
    if (wb_data[15])        cc_next = 3'b100;
    else if (wb_data == '0) cc_next = 3'b010;
    else                    cc_next = 3'b001;
  end

  // Writeback runs independently of both handshakes, including during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cc <= RESET_CC;
    else if (wb_en && wb_setcc) cc <= cc_next;
  end

  assign {cc_n, cc_z, cc_p} = cc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_regA   <= '0;
      out_regB   <= '0;
      out_dr     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_instr;
      out_regA   <= rd_a;
      out_regB   <= rd_b;
      out_dr     <= sra;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/lc3_decode_rf.md
Name: lc3_decode_rf

Overview:
Decode and operand-fetch stage that sits directly upstream of the LC3 ALU.
- Accepts 16-bit instructions over a valid/ready handshake.
- Reads two operands from an 8x16 register file.
- Presents {opcode, regA, regB} to the ALU through a single output pipeline register.
- Owns the register file write port and the architectural n/z/p condition register, which are updated from the writeback path.

Parameters:
NREGS, 8, number of general registers; must be a power of two (index width = log2(NREGS) = 3).
RESET_CC, 3'b010, reset value of {n,z,p}.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept an instruction
in_instr  in  16  instruction: [15:12] ALUop, [11:9] DR/SRA, [8] mode, [7:0] imm8, [2:0] SRB
out_valid  out  1  output register holds a valid operation
out_ready  in  1  ALU consumes the operation this cycle
out_opcode  out  16  instruction, forwarded unmodified
out_regA  out  16  R[instr[11:9]]
out_regB  out  16  R[instr[2:0]]
out_dr  out  3  destination index (instr[11:9])
wb_en  in  1  register file write enable
wb_addr  in  3  write index
wb_data  in  16  write data
wb_setcc  in  1  update n/z/p from wb_data (qualified by wb_en)
cc_n, cc_z, cc_p  out  1 each  condition register, one-hot

Behaviour:
- Reset (asynchronous, rst_n low):
  - All registers R0..R7 = 0.
  - out_valid = 0; out_opcode/out_regA/out_regB/out_dr = 0.
  - {cc_n,cc_z,cc_p} = RESET_CC.
  - in_ready is combinational and is therefore 1 while in reset.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready.
  - On accept: the output register loads the decoded fields at the next rising edge; out_valid = 1.
  - Latency is 1 cycle, input to output.
  - When out_valid & out_ready and no new accept: out_valid drops to 0 next cycle.
  - Simultaneous consume and accept: the output register reloads and out_valid stays 1, sustaining full throughput of one instruction per cycle.
- Stall: while out_valid & !out_ready, all out_* hold stable and in_ready = 0.
- Decode: no opcode-dependent operand selection. regA always reads index [11:9]; regB always reads index [2:0]. The ALU interprets mode/imm8.
- Register file:
  - Write on rising edge when wb_en.
  - R0 is a normal writable register.
  - Writes are independent of both handshakes and proceed during stalls.
- Read/write same cycle, same index (accept cycle, wb_en with wb_addr equal to a read index): behaviour is defined under Optional Feature.
- Condition register:
  - Updates on rising edge when wb_en & wb_setcc.
  - wb_data[15] = 1 -> 100. wb_data == 0 -> 010. Otherwise -> 001.
  - Always exactly one bit set.
  - wb_setcc without wb_en: no effect.
- Stale operands: operands captured in a stalled output register are NOT refreshed by later writebacks. Hazard avoidance is the issuer's responsibility.
- Opcodes 1100-1111: passed through unmodified; no special handling.

Optional Feature:
Macro: LC3_WB_BYPASS_EN.
- Defined: on an accept cycle, if wb_en and wb_addr matches a read index, that operand is taken from wb_data, i.e. the new value (write-before-read). Both operands bypass independently.
- Undefined: operands read the pre-write register contents, i.e. the old value. The written value becomes visible to instructions accepted from the next cycle onward.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, cc = 010, and R0..R7 read 0 on subsequent accepts.
- Write then read: wb_en with R3=16'h1234 and R5=16'h00FF on separate cycles; then accept instr 16'h06_05 (DR=3, SRB=5) -> one cycle later out_regA=1234, out_regB=00FF, out_dr=3, out_opcode=0605.
- Stall hold: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs frozen; then out_ready=1 -> back-to-back instructions advance one per cycle with no bubbles or drops.
- Condition codes:
  - wb_data=8000, setcc=1 -> cc=100.
  - wb_data=0000 -> cc=010.
  - wb_data=0001 -> cc=001.
  - wb_setcc=1 with wb_en=0 -> cc unchanged.
- Same-cycle bypass: R2=0011; accept instr reading R2 as SRA while wb_en writes R2=00AA -> out_regA=00AA if LC3_WB_BYPASS_EN is defined, 0011 otherwise; the next instruction reads 00AA in both builds.
